// File: rtl/nsr_lif_sequencer_pkg.sv
// nsr_pkg: shared definitions for the NSR LIF update sequencer.
//   - vector-length codes (VL_*)
//   - sequencer state enum
//   - vl_count(): neurons per pass for a vector-length code
package nsr_pkg;

  localparam logic [1:0] VL_1   = 2'b00;
  localparam logic [1:0] VL_4   = 2'b01;
  localparam logic [1:0] VL_16  = 2'b10;
  localparam logic [1:0] VL_ILL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Neurons touched by one pass; the illegal code touches none.
  function automatic logic [4:0] vl_count(input logic [1:0] vl);
    case (vl)
      VL_1:    return 5'd1;
      VL_4:    return 5'd4;
      VL_16:   return 5'd16;
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/nsr_lif_sequencer_lif_update.sv
// lif_update: combinational LIF datapath for one neuron.
//   cur        in  DW  current membrane value (signed)
//   stim       in  DW  stimulus (signed)
//   vt         in  DW  firing threshold (signed)
//   leak_shift in  5   leak shift; 0 disables leak
//   next_cur   out DW  saturated leaked+stimulus value (before fire reset)
//   fire       out 1   next_cur >= vt
module lif_update #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] cur,
  input  logic [DW-1:0] stim,
  input  logic [DW-1:0] vt,
  input  logic [4:0]    leak_shift,
  output logic [DW-1:0] next_cur,
  output logic          fire
);

  logic [DW-1:0] decay;
  logic [DW-1:0] leaked;
  logic [DW:0]   sum_ext;

  // Arithmetic shift: decay rounds toward minus infinity, so a negative
  // membrane leaks toward zero just like a positive one. A shift of zero
  // would subtract the whole value, hence the explicit bypass.
  assign decay  = $signed(cur) >>> leak_shift;
  assign leaked = (leak_shift == 5'd0) ? cur : cur - decay;

  // One guard bit catches overflow; mismatched top bits mean we clip.
  assign sum_ext = {leaked[DW-1], leaked} + {stim[DW-1], stim};

  always_comb begin
    next_cur = sum_ext[DW-1:0];
    if (sum_ext[DW] != sum_ext[DW-1]) begin
      next_cur = sum_ext[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
  end

  assign fire = $signed(next_cur) >= $signed(vt);

endmodule

// File: rtl/nsr_lif_sequencer.sv
// nsr_lif_sequencer: sequences one LIF update pass over a 1/4/16-entry
// window of the NSR file, one neuron per cycle.
//   clk, rst (async, active-high)
//   start, vl, base, vt, leak_shift  pass request and its configuration
//   stim_idx / stim_data             stimulus lookup for the current neuron
//   nsr_ra / nsr_rd                  NSR read port (combinational data)
//   nsr_we / nsr_wa / nsr_wd         NSR write port (commits on clk)
//   busy, done, err, spikes          pass status and per-neuron fire bits
module nsr_lif_sequencer
  import nsr_pkg::*;
#(
  parameter int NREG = 32,
  parameter int DW   = 32,
  parameter int MAXN = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      vl,
  input  logic [4:0]      base,
  input  logic [DW-1:0]   vt,
  input  logic [4:0]      leak_shift,
  output logic [3:0]      stim_idx,
  input  logic [DW-1:0]   stim_data,
  output logic [4:0]      nsr_ra,
  input  logic [DW-1:0]   nsr_rd,
  output logic            nsr_we,
  output logic [4:0]      nsr_wa,
  output logic [DW-1:0]   nsr_wd,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [MAXN-1:0] spikes
);

  state_t          state_q, state_d;
  logic [3:0]      i_q, i_d;
  logic [1:0]      vl_q, vl_d;
  logic [4:0]      base_q, base_d;
  logic [DW-1:0]   vt_q, vt_d;
  logic [4:0]      shift_q, shift_d;
  logic [MAXN-1:0] spikes_q, spikes_d;

  logic            run;
  logic [4:0]      run_addr;
  logic [4:0]      last_idx;
  logic [DW-1:0]   next_cur;
  logic            fire;

  assign run      = (state_q == RUN);
  assign run_addr = 5'((32'(base_q) + 32'(i_q)) % NREG);
  assign last_idx = vl_count(vl_q) - 5'd1;

  lif_update #(.DW(DW)) u_lif (
    .cur        (nsr_rd),
    .stim       (stim_data),
    .vt         (vt_q),
    .leak_shift (shift_q),
    .next_cur   (next_cur),
    .fire       (fire)
  );

  always_comb begin
    // NOTE: every variable is given its hold value first so no path through
    // the case below leaves one unassigned and infers a latch.
    state_d  = state_q;
    i_d      = i_q;
    vl_d     = vl_q;
    base_d   = base_q;
    vt_d     = vt_q;
    shift_d  = shift_q;
    spikes_d = spikes_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          vl_d     = vl;
          base_d   = base;
          vt_d     = vt;
          shift_d  = leak_shift;
          spikes_d = '0;
          i_d      = '0;
          state_d  = (vl == VL_ILL) ? FIN : RUN;
        end
      end
      RUN: begin
        spikes_d[i_q] = fire;
        if ({1'b0, i_q} == last_idx) begin
          state_d = FIN;
        end else begin
          i_d = i_q + 4'd1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      i_q      <= '0;
      vl_q     <= VL_1;
      base_q   <= '0;
      vt_q     <= '0;
      shift_q  <= '0;
      spikes_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      i_q      <= i_d;
      vl_q     <= vl_d;
      base_q   <= base_d;
      vt_q     <= vt_d;
      shift_q  <= shift_d;
      spikes_q <= spikes_d;
    end
  end

  // Read and write target the same entry; the read sees the old value
  // because the NSR file only updates at the clock edge.
  assign nsr_we   = run;
  assign nsr_ra   = run ? run_addr : '0;
  assign nsr_wa   = run ? run_addr : '0;
  assign nsr_wd   = (run && !fire) ? next_cur : '0;
  assign stim_idx = run ? i_q : '0;

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == FIN);
  assign err    = done && (vl_q == VL_ILL);
  assign spikes = spikes_q;

endmodule

// File: tb/tb_nsr_lif_sequencer.sv
module tb_nsr_lif_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  vl;
  logic [4:0]  base;
  logic [31:0] vt;
  logic [4:0]  leak_shift;
  logic [3:0]  stim_idx;
  logic [31:0] stim_data;
  logic [4:0]  nsr_ra;
  logic [31:0] nsr_rd;
  logic        nsr_we;
  logic [4:0]  nsr_wa;
  logic [31:0] nsr_wd;
  logic        busy, done, err;
  logic [15:0] spikes;

  always #5 clk = ~clk;

  nsr_lif_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .vl(vl), .base(base), .vt(vt),
    .leak_shift(leak_shift), .stim_idx(stim_idx), .stim_data(stim_data),
    .nsr_ra(nsr_ra), .nsr_rd(nsr_rd), .nsr_we(nsr_we), .nsr_wa(nsr_wa),
    .nsr_wd(nsr_wd), .busy(busy), .done(done), .err(err), .spikes(spikes)
  );

  // NSR file and stimulus source emulation
  logic [31:0] mem [32];
  logic [31:0] stim_arr [16];
  logic        tb_we = 1'b0;
  logic [4:0]  tb_wa = '0;
  logic [31:0] tb_wd = '0;
  int          wr_count = 0;
  int          wr_bad = 0;

  assign nsr_rd    = mem[nsr_ra];
  assign stim_data = stim_arr[stim_idx];

  always @(posedge clk) begin
    if (nsr_we) begin
      mem[nsr_wa] <= nsr_wd;
      wr_count++;
      if (nsr_ra !== nsr_wa) wr_bad++;
    end else if (tb_we) begin
      mem[tb_wa] <= tb_wd;
    end
  end

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [32];
  logic [31:0] exp_mem [32];
  logic [15:0] exp_sp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int count_of(input logic [1:0] v);
    return (v == 2'd0) ? 1 : (v == 2'd1) ? 4 : (v == 2'd2) ? 16 : 0;
  endfunction

  // LIF rule in plain integer arithmetic: arithmetic shift == floor division.
  function automatic logic [31:0] lif_ref(input logic [31:0] cur_u, input logic [31:0] stim_u,
                                          input logic [31:0] vt_u, input logic [4:0] sh,
                                          output bit fire);
    longint cur, stim, thr, d, q, leaked, sum, maxv, minv;
    cur  = longint'($signed(cur_u));
    stim = longint'($signed(stim_u));
    thr  = longint'($signed(vt_u));
    maxv = (longint'(1) << 31) - 1;
    minv = -(longint'(1) << 31);
    d = longint'(1) << sh;
    q = cur / d;
    if (cur < 0 && (cur % d) != 0) q = q - 1;
    leaked = (sh == 5'd0) ? cur : cur - q;
    sum = leaked + stim;
    if (sum > maxv) sum = maxv;
    if (sum < minv) sum = minv;
    fire = (sum >= thr);
    return fire ? 32'h0 : sum[31:0];
  endfunction

  task automatic apply_model(input logic [4:0] b, input logic [31:0] t, input logic [4:0] s,
                             input int cnt);
    bit f;
    int a;
    exp_mem = ref_mem;
    exp_sp  = '0;
    for (int i = 0; i < cnt; i++) begin
      a = (int'(b) + i) % 32;
      exp_mem[a] = lif_ref(exp_mem[a], stim_arr[i], t, s, f);
      exp_sp[i]  = f;
    end
  endtask

  // Preload one NSR entry through the bench write port (DUT must be idle).
  task automatic load(input int a, input logic [31:0] d);
    tb_we = 1'b1;
    tb_wa = 5'(a);
    tb_wd = d;
    @(posedge clk);
    #1 tb_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic compare_mem(input string name);
    int bad = 0;
    for (int k = 0; k < 32; k++) if (mem[k] !== exp_mem[k]) bad++;
    check(name, 64'(bad), 64'd0);
  endtask

  // Entered and left at posedge+1. extra_cyc pulses a start mid-pass that
  // must be ignored; chain leaves us in the IDLE cycle right after done.
  task automatic run_pass(input logic [1:0] v, input logic [4:0] b, input logic [31:0] t,
                          input logic [4:0] s, input int extra_cyc, input bit chain);
    int n, done_cyc, w0;
    bit busy_ok, we_bad, err_s;
    n = count_of(v);
    apply_model(b, t, s, n);
    w0 = wr_count;
    done_cyc = -1; busy_ok = 1; we_bad = 0; err_s = 0;
    vl = v; base = b; vt = t; leak_shift = s; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    // Scramble the request inputs: the pass must use the latched copies.
    vl = 2'b11; base = ~b; vt = ~t; leak_shift = ~s;
    for (int c = 1; c <= 40; c++) begin
      start = (c == extra_cyc);
      @(negedge clk);
      if (busy !== 1'b1) busy_ok = 0;
      if (c > n && nsr_we !== 1'b0) we_bad = 1;
      if (done === 1'b1 && done_cyc < 0) begin
        done_cyc = c;
        err_s = err;
      end
      @(posedge clk);
      #1 start = 1'b0;
      if (done_cyc >= 0) break;
    end
    check("done_cycle", 64'(done_cyc), 64'(n + 1));
    check("err_at_done", 64'(err_s), 64'(v == 2'b11));
    check("busy_during_pass", 64'(busy_ok), 64'd1);
    check("we_outside_run", 64'(we_bad), 64'd0);
    check("write_count", 64'(wr_count - w0), 64'(n));
    check("ra_eq_wa", 64'(wr_bad), 64'd0);
    check("spikes", 64'(spikes), 64'(exp_sp));
    compare_mem("nsr_contents");
    ref_mem = exp_mem;
    if (!chain) begin
      @(negedge clk);
      check("idle_after_pass", {61'd0, busy, nsr_we, done}, 64'd0);
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'($signed($urandom_range(0, 2000)) - 1000);
      2:       return 32'h7FFF_FF00 + 32'($urandom_range(0, 255));
      default: return 32'h8000_0000 + 32'($urandom_range(0, 255));
    endcase
  endfunction

  typedef struct {
    logic [1:0]  vl;
    logic [4:0]  base;
    logic [31:0] vt;
    logic [4:0]  sh;
    logic [31:0] cur;
    logic [31:0] stim;
    logic [31:0] exp_val;
    logic [15:0] exp_sp;
    int          extra;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{2'b00, 5'd5,  32'd200,        5'd0, 32'd100,        32'd50,         32'd150,        16'h0000, 2};
    tbl[1] = '{2'b01, 5'd0,  32'd200,        5'd0, 32'd190,        32'd10,         32'd0,          16'h000F, -1};
    tbl[2] = '{2'b01, 5'd30, 32'd1000,       5'd2, 32'd64,         32'd0,          32'd48,         16'h0000, -1};
    tbl[3] = '{2'b00, 5'd7,  32'h7FFF_FFFF,  5'd0, 32'h7FFF_FFF0,  32'h100,        32'd0,          16'h0001, -1};
    tbl[4] = '{2'b10, 5'd10, 32'd0,          5'd1, 32'hFFFF_FF9C,  32'd20,         32'hFFFF_FFE2,  16'h0000, 5};
    tbl[5] = '{2'b11, 5'd3,  32'd0,          5'd0, 32'd77,         32'd5,          32'd77,         16'h0000, -1};
    tbl[6] = '{2'b00, 5'd31, 32'd0,          5'd0, 32'h8000_0010,  32'hFFFF_FF00,  32'h8000_0000,  16'h0000, -1};

    rst = 1'b1; start = 1'b0; vl = '0; base = '0; vt = '0; leak_shift = '0;
    for (int i = 0; i < 16; i++) stim_arr[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_status", {60'd0, busy, done, err, nsr_we}, 64'd0);
    check("reset_spikes", 64'(spikes), 64'd0);
    check("reset_addrs", {50'd0, nsr_ra, nsr_wa, stim_idx}, 64'd0);
    check("reset_wd", 64'(nsr_wd), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 32; k++) load(k, 32'(k * 3));

    // Directed vectors
    for (int r = 0; r < 7; r++) begin
      int n, nchk, bad;
      n = count_of(tbl[r].vl);
      nchk = (n == 0) ? 1 : n;
      for (int i = 0; i < nchk; i++) load((int'(tbl[r].base) + i) % 32, tbl[r].cur);
      for (int i = 0; i < 16; i++) stim_arr[i] = tbl[r].stim;
      run_pass(tbl[r].vl, tbl[r].base, tbl[r].vt, tbl[r].sh, tbl[r].extra, 1'b0);
      bad = 0;
      for (int i = 0; i < nchk; i++)
        if (mem[(int'(tbl[r].base) + i) % 32] !== tbl[r].exp_val) bad++;
      check($sformatf("vec%0d_values", r), 64'(bad), 64'd0);
      check($sformatf("vec%0d_spikes", r), 64'(spikes), 64'(tbl[r].exp_sp));
    end

    // Back-to-back start in the IDLE cycle right after done
    for (int i = 0; i < 16; i++) stim_arr[i] = 32'(i * 7);
    run_pass(2'b00, 5'd12, 32'd500, 5'd3, -1, 1'b1);
    run_pass(2'b01, 5'd20, 32'd60,  5'd1, -1, 1'b0);

    // Reset in cycle 3 of a 16-neuron pass
    begin
      int w0;
      for (int i = 0; i < 16; i++) load((8 + i) % 32, 32'(100 + i));
      for (int i = 0; i < 16; i++) stim_arr[i] = 32'd1;
      apply_model(5'd8, 32'd1_000_000, 5'd0, 2);
      w0 = wr_count;
      vl = 2'b10; base = 5'd8; vt = 32'd1_000_000; leak_shift = 5'd0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("rst_mid_status", {61'd0, busy, nsr_we, done}, 64'd0);
      check("rst_mid_spikes", 64'(spikes), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      check("rst_mid_writes", 64'(wr_count - w0), 64'd2);
      compare_mem("rst_mid_contents");
      ref_mem = exp_mem;
    end

    // Randomised passes against the reference model
    for (int p = 0; p < 30; p++) begin
      logic [1:0] rv;
      int ex;
      rv = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      for (int k = 0; k < 32; k++) load(k, rnd32());
      for (int i = 0; i < 16; i++) stim_arr[i] = rnd32();
      ex = ($urandom_range(0, 1) == 1) ? $urandom_range(1, count_of(rv) + 1) : -1;
      run_pass(rv, 5'($urandom), rnd32(),
               ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom), ex, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
